// File: rtl/conv2x2_ctrl_if.sv
// rtl/conv2x2_ctrl_if.sv - control, image-memory, conv-core and result signals of conv2x2_ctrl
interface conv2x2_ctrl_if #(
    parameter int AW = 12
);
    logic          start;
    logic [31:0]   filt_in;
    logic          busy;
    logic          done;
    logic          img_rd_en;
    logic [AW-1:0] img_rd_addr;
    logic [7:0]    img_rd_data;
    logic [31:0]   core_image;
    logic [31:0]   core_filter;
    logic [15:0]   core_out;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic [11:0]   res_idx;

    modport master (
        input  start, filt_in, img_rd_data, core_out, res_ready,
        output busy, done, img_rd_en, img_rd_addr, core_image, core_filter,
               res_valid, res_data, res_idx
    );

    modport slave (
        output start, filt_in, img_rd_data, core_out, res_ready,
        input  busy, done, img_rd_en, img_rd_addr, core_image, core_filter,
               res_valid, res_data, res_idx
    );
endinterface

// File: rtl/conv2x2_ctrl.sv
// rtl/conv2x2_ctrl.sv - walks 2x2 windows over an image, feeds a conv core and streams results
module conv2x2_ctrl #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int AW       = 12,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    conv2x2_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, CAP, LAT, OUT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [7:0]    lat_q, lat_d;
    logic [6:0]    r_q, r_d;
    logic [6:0]    c_q, c_d;
    logic [11:0]   idx_q, idx_d;
    logic [31:0]   img_q, img_d;
    logic [31:0]   filt_q, filt_d;
    logic          done_q, done_d;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          last_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            lat_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            img_q   <= '0;
            filt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
            r_q     <= r_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            img_q   <= img_d;
            filt_q  <= filt_d;
            done_q  <= done_d;
        end
    end

    assign base     = AW'(r_q) * AW'(IMG_W) + AW'(c_q);
    assign last_win = (r_q == 7'(IMG_H - 2)) && (c_q == 7'(IMG_W - 2));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lat_d   = lat_q;
        r_d     = r_q;
        c_d     = c_q;
        idx_d   = idx_q;
        img_d   = img_q;
        filt_d  = filt_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    filt_d  = bus.filt_in;
                    r_d     = '0;
                    c_d     = '0;
                    idx_d   = '0;
                    k_d     = '0;
                end
            end
            FETCH: begin
                rd_en = 1'b1;
                case (k_q)
                    2'd0: rd_addr = base;
                    2'd1: rd_addr = base + AW'(1);
                    2'd2: rd_addr = base + AW'(IMG_W);
                    default: rd_addr = base + AW'(IMG_W) + AW'(1);
                endcase
                // Memory data lags the strobe by one cycle, so read k lands while issuing read k+1.
                case (k_q)
                    2'd1: img_d[31:24] = bus.img_rd_data;
                    2'd2: img_d[23:16] = bus.img_rd_data;
                    2'd3: img_d[15:8]  = bus.img_rd_data;
                    default: ;
                endcase
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = CAP;
            end
            CAP: begin
                img_d[7:0] = bus.img_rd_data;
                lat_d      = '0;
                state_d    = LAT;
            end
            LAT: begin
                lat_d = lat_q + 8'd1;
                if (lat_q >= 8'(CORE_LAT - 1)) state_d = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    idx_d = idx_q + 12'd1;
                    if (last_win) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        k_d     = '0;
                        if (c_q == 7'(IMG_W - 2)) begin
                            c_d = '0;
                            r_d = r_q + 7'd1;
                        end else begin
                            c_d = c_q + 7'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.img_rd_en   = rd_en;
    assign bus.img_rd_addr = rd_addr;
    assign bus.core_image  = img_q;
    assign bus.core_filter = filt_q;
    assign bus.res_valid   = (state_q == OUT);
    assign bus.res_data    = (state_q == OUT) ? bus.core_out : 16'd0;
    assign bus.res_idx     = idx_q;
endmodule

// File: tb/tb_conv2x2_ctrl.sv
// tb/tb_conv2x2_ctrl.sv - scoreboard bench for conv2x2_ctrl on a 4x3 image
module tb_conv2x2_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NW = (W - 1) * (H - 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv2x2_ctrl_if #(.AW(12)) bus ();

    conv2x2_ctrl #(.IMG_W(W), .IMG_H(H), .AW(12), .CORE_LAT(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  mem [W*H];
    logic [11:0] addr_q [$];
    logic [27:0] res_q  [$];
    logic [15:0] p1, p2;
    bit          rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(a[31-8*i -: 8]) * int'(b[31-8*i -: 8]);
        return s[15:0];
    endfunction

    // Reference conv core with two-stage latency and an image memory with one-cycle read latency.
    always @(posedge clk) begin
        p1 <= conv(bus.core_image, bus.core_filter);
        p2 <= p1;
        if (bus.img_rd_en) bus.img_rd_data <= mem[bus.img_rd_addr];
    end
    assign bus.core_out = p2;

    always @(posedge clk) if (rdy_rand) #1 bus.res_ready = 1'($urandom_range(0, 1));

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.img_rd_en) begin
                if (addr_q.size() == 0) check("rd_addr_extra", 32'(bus.img_rd_addr), 32'hFFFF);
                else check("rd_addr", 32'(bus.img_rd_addr), 32'(addr_q.pop_front()));
            end
            if (bus.res_valid && bus.res_ready) begin
                if (res_q.size() == 0) check("res_extra", {4'h0, bus.res_idx, bus.res_data}, 32'hFFFF_FFFF);
                else check("res", {4'h0, bus.res_idx, bus.res_data}, {4'h0, res_q.pop_front()});
            end
        end
    end

    task automatic push_frame(input logic [31:0] f, input bit all255);
        int r, c, a;
        logic [31:0] win;
        for (int i = 0; i < NW; i++) begin
            r = i / (W - 1);
            c = i % (W - 1);
            a = r * W + c;
            addr_q.push_back(12'(a));
            addr_q.push_back(12'(a + 1));
            addr_q.push_back(12'(a + W));
            addr_q.push_back(12'(a + W + 1));
            win = {mem[a], mem[a+1], mem[a+W], mem[a+W+1]};
            res_q.push_back({12'(i), all255 ? 16'd63492 : conv(win, f)});
        end
    endtask

    task automatic pulse_start(input logic [31:0] f);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.filt_in = f;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.filt_in = 32'h0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!bus.done && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_hs(input int idx);
        int n;
        n = 0;
        while (!(bus.res_valid && bus.res_ready && bus.res_idx == 12'(idx)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("hs_timeout", 32'(n < 500), 32'd1);
    endtask

    task automatic run_frame(input logic [31:0] f, input bit all255, input bit chk_cycles);
        int cyc;
        push_frame(f, all255);
        pulse_start(f);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        wait_done(cyc);
        if (chk_cycles) check("frame_cycles", 32'(cyc), 32'(NW * 8));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_rd_en"}, 32'(bus.img_rd_en), 0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_rd_addr"}, 32'(bus.img_rd_addr), 0);
        check({tag, "_core_image"}, bus.core_image, 0);
        check({tag, "_core_filter"}, bus.core_filter, 0);
        check({tag, "_res_idx"}, 32'(bus.res_idx), 0);
    endtask

    initial begin
        logic [31:0] fd;
        logic [15:0] sd;
        logic [11:0] si;
        int          cyc, n;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.filt_in   = 32'h0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < W * H; i++) mem[i] = 8'(i + 1);
        run_frame(32'h0100_0001, 1'b0, 1'b1);

        for (int i = 0; i < W * H; i++) mem[i] = 8'hFF;
        run_frame(32'hFFFF_FFFF, 1'b1, 1'b1);

        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
        rdy_rand = 1'b1;
        run_frame($urandom, 1'b0, 1'b0);
        rdy_rand = 1'b0;
        @(posedge clk);
        #1 bus.res_ready = 1'b1;

        // Stall window 1 for five cycles, then a stray start with a different filter mid-frame.
        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
        fd = $urandom;
        push_frame(fd, 1'b0);
        pulse_start(fd);
        wait_hs(0);
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        sd = bus.res_data;
        si = bus.res_idx;
        check("stall_idx", 32'(si), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.res_valid), 32'd1);
            check("stall_data", 32'(bus.res_data), 32'(sd));
            check("stall_res_idx", 32'(bus.res_idx), 32'(si));
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("fetch_after_hs", 32'(bus.img_rd_en), 32'd1);
        pulse_start(~fd);
        check("filter_kept_mid", bus.core_filter, fd);
        wait_done(cyc);
        check("filter_kept_end", bus.core_filter, fd);

        // Reset during LAT of window 2: handshake of window 1, then FETCH x4, CAP, LAT.
        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
        fd = $urandom;
        push_frame(fd, 1'b0);
        pulse_start(fd);
        wait_hs(1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        addr_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'(bus.busy), 32'd0);

        for (int i = 0; i < W * H; i++) mem[i] = 8'(i + 1);
        run_frame(32'h0100_0001, 1'b0, 1'b1);

        check("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        check("res_queue_empty", 32'(res_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv2x2_ctrl.md
CONV2X2_CTRL -- requirements
Module: conv2x2_ctrl

Interface
REQ-001 Parameter: IMG_W, 8, image width in pixels; legal range 2..64.
REQ-002 Parameter: IMG_H, 8, image height in pixels; legal range 2..64.
REQ-003 Parameter: AW, 12, image-memory address width; AW >= clog2(IMG_W*IMG_H).
REQ-004 Parameter: CORE_LAT, 2, clock edges from a stable core_image/core_filter to a valid core_out.
REQ-005 clk  input  1  clock; rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame.
REQ-007 filt_in  input  32  packed weights: f00 in [31:24], f01 in [23:16], f10 in [15:8], f11 in [7:0].
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse after the last result is accepted.
REQ-010 img_rd_en  output  1  image-memory read strobe; read data returns one cycle later.
REQ-011 img_rd_addr  output  AW  row-major pixel address, row*IMG_W+col.
REQ-012 img_rd_data  input  8  unsigned pixel returned by the memory.
REQ-013 core_image, core_filter  output  32  window and weights driven to the 2x2 conv core, using the same byte packing as filt_in.
REQ-014 core_out  input  16  conv core result.
REQ-015 res_valid  output  1  result-valid handshake; res_ready  input  1  sink ready.
REQ-016 res_data  output  16  result value; res_idx  output  12  window index = r*(IMG_W-1)+c.

Function
REQ-017 FSM states: IDLE, FETCH, CAP, LAT, OUT.
- IDLE -> FETCH on start; the block latches filt_in into core_filter on that edge.
REQ-018 FETCH lasts 4 cycles with img_rd_en=1 and addresses, in order:
- k=0: (r,c)
- k=1: (r,c+1)
- k=2: (r+1,c)
- k=3: (r+1,c+1)
REQ-019 Byte placement: the data for read k is written into core_image byte k, where byte 0 = [31:24], on the edge ending the cycle after the read.
- FETCH cycles 1..3 capture k=0..2.
- CAP (1 cycle, img_rd_en=0) captures k=3.
REQ-020 LAT holds core_image and core_filter stable for CORE_LAT cycles, then the FSM moves to OUT.
REQ-021 OUT behaviour:
- res_valid=1; res_data = core_out; res_idx = current index.
- All three stay stable, and core_image stays held, until res_valid&&res_ready.
REQ-022 On handshake in OUT:
- If more windows remain: advance c; at c=IMG_W-2, wrap c to 0 and increment r; go to FETCH.
- After window (IMG_H-2, IMG_W-2): go to IDLE and pulse done.
REQ-023 Windows per frame: (IMG_W-1)*(IMG_H-1).
- Minimum 8 cycles per window with res_ready held high (FETCH 4 + CAP 1 + LAT 2 + OUT 1).
REQ-024 Start while busy is ignored; filt_in is sampled only at accepted start.
REQ-025 Arithmetic: pixels and weights are unsigned 8-bit; the sum is modulo 2^16, matching the core; the controller performs no arithmetic on results.
REQ-026 Simultaneous start and final handshake: done pulses and the start is ignored; a new start is accepted only in IDLE.
REQ-027 res_ready low in any state other than OUT has no effect.

Reset
REQ-028 Asynchronous assertion of rst_n forces IDLE in any state, including mid-frame.
- busy, done, img_rd_en, res_valid = 0.
- img_rd_addr, core_image, core_filter, res_idx = 0; r = c = 0.
REQ-029 After reset deassertion the block waits for a new start; no partial frame resumes.

Verification
REQ-030 IMG_W=IMG_H=3, pixels 1..9, filt_in=0x01000001, res_ready=1 -> results 6, 8, 12, 14 at res_idx 0..3; done after 4 handshakes; frame 32 cycles.
REQ-031 All pixels 255, filt_in=0xFFFFFFFF -> every res_data = 63492 (260100 mod 65536).
REQ-032 res_ready low for 5 cycles during OUT of window 1 -> res_valid, res_data, res_idx held stable; the next window's FETCH begins the cycle after the handshake.
REQ-033 Second start mid-frame with a different filt_in -> ignored; results and core_filter are unchanged.
REQ-034 rst_n asserted during LAT of window 2 -> all outputs 0 immediately; a fresh start restarts from window 0 at address 0.
REQ-035 IMG_W=4, IMG_H=3 -> read address sequence 0,1,4,5 | 1,2,5,6 | 2,3,6,7 | 4,5,8,9 ...; 6 results; res_idx 0..5.
